// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared types and constants for the physical-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   side_t      : identifies a requester (I-cache or D-cache)
//   LINE_W      : cache-line width in bits
//   ADDR_W      : line address width in bits
// -----------------------------------------------------------------------------
package rv32i_types;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

endpackage

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//   Shares one cacheline adaptor between the I-cache and the D-cache.
//   Requests are sampled only in IDLE; the granted request (op, address,
//   wdata) is latched and replayed to the adaptor until main_resp, so the
//   requester may change or drop its request mid-transfer.
//
//   Parameters
//     D_PRIORITY   : 1 = D-side wins ties (bounded by STARVE_LIMIT),
//                    0 = ties go to the side opposite the last grant
//     STARVE_LIMIT : max consecutive D grants while I is pending
//
//   Ports
//     clk, reset_n             : clock, asynchronous active-low reset
//     i_pmem_* / d_pmem_*      : cache-side read/write/address/wdata in,
//                                rdata/resp out
//     main_read/main_write     : registered strobes to the adaptor
//     main_address/main_wdata  : registered request payload to the adaptor
//     main_rdata/main_resp     : adaptor read line and completion
// -----------------------------------------------------------------------------
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int D_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              main_read,
    output logic              main_write,
    output logic [ADDR_W-1:0] main_address,
    output logic [LINE_W-1:0] main_wdata,
    input  logic [LINE_W-1:0] main_rdata,
    input  logic              main_resp
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q;
    logic              main_read_q;
    logic              main_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    side_t             last_grant_q;

    logic  i_req;
    logic  d_req;
    side_t grant_side;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    // Winner when both sides request in the same IDLE cycle.
    function automatic side_t tie_winner(input logic [CNT_W-1:0] cnt, input side_t last);
        if (D_PRIORITY != 0) begin
            return (cnt == STARVE_MAX) ? SIDE_I : SIDE_D;
        end
        return (last == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

    // NOTE: default assigned first so every path drives grant_side and no latch is inferred.
    always_comb begin
        grant_side = SIDE_I;
        if (i_req && d_req) begin
            grant_side = tie_winner(starve_cnt_q, last_grant_q);
        end else if (d_req) begin
            grant_side = SIDE_D;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            main_read_q  <= 1'b0;
            main_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
            last_grant_q <= SIDE_I;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        last_grant_q <= grant_side;
                        if (grant_side == SIDE_D) begin
                            state_q      <= BUSY_D;
                            // read+write together is treated as a write
                            main_write_q <= d_pmem_write;
                            main_read_q  <= ~d_pmem_write;
                            addr_q       <= d_pmem_address;
                            wdata_q      <= d_pmem_wdata;
                            if (i_req && (starve_cnt_q != STARVE_MAX)) begin
                                starve_cnt_q <= starve_cnt_q + 1'b1;
                            end
                        end else begin
                            state_q      <= BUSY_I;
                            main_write_q <= i_pmem_write;
                            main_read_q  <= ~i_pmem_write;
                            addr_q       <= i_pmem_address;
                            wdata_q      <= i_pmem_wdata;
                            starve_cnt_q <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Return to IDLE for at least one cycle; no grant here.
                    if (main_resp) begin
                        state_q      <= IDLE;
                        main_read_q  <= 1'b0;
                        main_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    main_read_q  <= 1'b0;
                    main_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign main_read    = main_read_q;
    assign main_write   = main_write_q;
    assign main_address = addr_q;
    assign main_wdata   = wdata_q;

    // Completion is routed combinationally to the granted side only; main_resp
    // in IDLE is ignored because neither BUSY state is active.
    assign i_pmem_resp  = (state_q == BUSY_I) && main_resp;
    assign d_pmem_resp  = (state_q == BUSY_D) && main_resp;
    assign i_pmem_rdata = i_pmem_resp ? main_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? main_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//   Two arbiter instances share the clock, reset and adaptor inputs:
//   dut_p (D_PRIORITY=1, STARVE_LIMIT=4) and dut_r (D_PRIORITY=0).
//   sel routes requester strobes to one instance and muxes its outputs
//   onto the o_* observation signals; the other instance idles.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;
    import rv32i_types::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;
    logic        i_read, i_write, d_read, d_write;
    logic [31:0] i_addr, d_addr;
    logic [255:0] i_wdata, d_wdata;
    logic        main_resp;
    logic [255:0] main_rdata;

    logic [255:0] p_i_rdata, p_d_rdata, r_i_rdata, r_d_rdata;
    logic         p_i_resp, p_d_resp, r_i_resp, r_d_resp;
    logic         p_main_read, p_main_write, r_main_read, r_main_write;
    logic [31:0]  p_main_address, r_main_address;
    logic [255:0] p_main_wdata, r_main_wdata;

    logic [255:0] o_i_rdata, o_d_rdata, o_main_wdata;
    logic         o_i_resp, o_d_resp, o_main_read, o_main_write;
    logic [31:0]  o_main_address;

    int checks = 0;
    int failures = 0;

    pmem_arbiter #(.D_PRIORITY(1), .STARVE_LIMIT(LIMIT)) dut_p (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_read & ~sel), .i_pmem_write(i_write & ~sel),
        .i_pmem_address(i_addr), .i_pmem_wdata(i_wdata),
        .i_pmem_rdata(p_i_rdata), .i_pmem_resp(p_i_resp),
        .d_pmem_read(d_read & ~sel), .d_pmem_write(d_write & ~sel),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(p_d_rdata), .d_pmem_resp(p_d_resp),
        .main_read(p_main_read), .main_write(p_main_write),
        .main_address(p_main_address), .main_wdata(p_main_wdata),
        .main_rdata(main_rdata), .main_resp(main_resp)
    );

    pmem_arbiter #(.D_PRIORITY(0), .STARVE_LIMIT(LIMIT)) dut_r (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_read & sel), .i_pmem_write(i_write & sel),
        .i_pmem_address(i_addr), .i_pmem_wdata(i_wdata),
        .i_pmem_rdata(r_i_rdata), .i_pmem_resp(r_i_resp),
        .d_pmem_read(d_read & sel), .d_pmem_write(d_write & sel),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(r_d_rdata), .d_pmem_resp(r_d_resp),
        .main_read(r_main_read), .main_write(r_main_write),
        .main_address(r_main_address), .main_wdata(r_main_wdata),
        .main_rdata(main_rdata), .main_resp(main_resp)
    );

    assign o_i_rdata      = sel ? r_i_rdata      : p_i_rdata;
    assign o_d_rdata      = sel ? r_d_rdata      : p_d_rdata;
    assign o_i_resp       = sel ? r_i_resp       : p_i_resp;
    assign o_d_resp       = sel ? r_d_resp       : p_d_resp;
    assign o_main_read    = sel ? r_main_read    : p_main_read;
    assign o_main_write   = sel ? r_main_write   : p_main_write;
    assign o_main_address = sel ? r_main_address : p_main_address;
    assign o_main_wdata   = sel ? r_main_wdata   : p_main_wdata;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic set_req(input bit is_d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [255:0] w);
        if (is_d) begin d_read = rd; d_write = wr; d_addr = a; d_wdata = w; end
        else      begin i_read = rd; i_write = wr; i_addr = a; i_wdata = w; end
    endtask

    task automatic drop_req(input bit is_d);
        if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
        else      begin i_read = 1'b0; i_write = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; main_resp = 1'b0;
        drop_req(1'b0); drop_req(1'b1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for a main strobe; called at a negedge, returns at one.
    task automatic wait_strobe(input string name, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int n = 0; n < 16 && !ok; n++) begin
            @(negedge clk);
            cyc++;
            ok = o_main_read | o_main_write;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_strobe: no main_read/main_write after %0d cycles", name, cyc);
        end
    endtask

    // Holds the transfer for lat cycles, then completes it with the given line.
    task automatic finish_txn(input string name, input bit is_d, input bit wr,
                              input logic [31:0] a, input int lat, input logic [255:0] line);
        logic got_r, oth_r;
        logic [255:0] got_d, oth_d;
        repeat (lat) begin
            @(negedge clk);
            checks++;
            if (o_main_address !== a || o_main_write !== wr || o_main_read !== !wr ||
                o_i_resp !== 1'b0 || o_d_resp !== 1'b0) begin
                failures++;
                $display("FAIL %s_hold: addr=%h wr=%b rd=%b iresp=%b dresp=%b, want addr=%h wr=%b no resp",
                         name, o_main_address, o_main_write, o_main_read, o_i_resp, o_d_resp, a, wr);
            end
        end
        main_rdata = line; main_resp = 1'b1;
        #1;
        got_r = is_d ? o_d_resp  : o_i_resp;
        oth_r = is_d ? o_i_resp  : o_d_resp;
        got_d = is_d ? o_d_rdata : o_i_rdata;
        oth_d = is_d ? o_i_rdata : o_d_rdata;
        checks++;
        if (got_r !== 1'b1 || got_d !== line || oth_r !== 1'b0 || oth_d !== '0 ||
            (o_main_read | o_main_write) !== 1'b1 || o_main_address !== a) begin
            failures++;
            $display("FAIL %s_resp: side_d=%0d resp=%b other_resp=%b strobe=%b addr=%h rdata=%h other=%h, want resp=1 other=0 strobe=1 addr=%h rdata=%h",
                     name, is_d, got_r, oth_r, o_main_read | o_main_write, o_main_address, got_d, oth_d, a, line);
        end
        @(posedge clk);
        #1;
        main_resp = 1'b0; main_rdata = rand_line();
        @(negedge clk);
        checks++;
        if (o_i_resp !== 1'b0 || o_d_resp !== 1'b0 || o_main_read !== 1'b0 || o_main_write !== 1'b0 ||
            o_i_rdata !== '0 || o_d_rdata !== '0) begin
            failures++;
            $display("FAIL %s_release: iresp=%b dresp=%b rd=%b wr=%b, want all 0 in IDLE",
                     name, o_i_resp, o_d_resp, o_main_read, o_main_write);
        end
    endtask

    task automatic check_grant(input string name, input bit wr, input logic [31:0] a,
                               input logic [255:0] w);
        checks++;
        if (o_main_write !== wr || o_main_read !== !wr || o_main_address !== a ||
            (wr && o_main_wdata !== w)) begin
            failures++;
            $display("FAIL %s_grant: wr=%b rd=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                     name, o_main_write, o_main_read, o_main_address, o_main_wdata, wr, a, w);
        end
    endtask

    // One full transaction; the strobe must appear one cycle after the
    // IDLE cycle in which the winning request was sampled.
    task automatic run_txn(input string name, input bit is_d, input bit wr,
                           input logic [31:0] a, input logic [255:0] w, input int lat);
        bit ok;
        int cyc;
        wait_strobe(name, ok, cyc);
        if (ok) begin
            checks++;
            if (cyc != 1) begin
                failures++;
                $display("FAIL %s_latency: strobe after %0d cycles, want 1", name, cyc);
            end
            check_grant(name, wr, a, w);
            finish_txn(name, is_d, wr, a, lat, rand_line());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o_main_read !== 1'b0 || o_main_write !== 1'b0 || o_i_resp !== 1'b0 || o_d_resp !== 1'b0 ||
            o_main_address !== '0 || o_main_wdata !== '0 || o_i_rdata !== '0 || o_d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h, want all 0",
                     o_main_read, o_main_write, o_i_resp, o_d_resp, o_main_address);
        end
        checks++;
        if (dut_p.starve_cnt_q !== '0) begin
            failures++;
            $display("FAIL reset_starve: starve_cnt=%0d want 0", dut_p.starve_cnt_q);
        end
        drop_req(1'b0); drop_req(1'b1); main_resp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_main_read !== 1'b0 || o_main_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_grant: rd=%b wr=%b want 0 with no request", o_main_read, o_main_write);
        end
    endtask

    task automatic test_lone_i_read();
        bit ok;
        int cyc;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0);
        wait_strobe("lone_i", ok, cyc);
        if (ok) begin
            checks++;
            if (cyc != 1) begin
                failures++;
                $display("FAIL lone_i_latency: %0d cycles want 1", cyc);
            end
            check_grant("lone_i", 1'b0, 32'h0000_0040, '0);
            finish_txn("lone_i", 1'b0, 1'b0, 32'h0000_0040, 1, {32{8'hAA}});
        end
        drop_req(1'b0);
        // Adaptor resp while IDLE must not reach either cache.
        main_resp = 1'b1;
        #1;
        checks++;
        if (o_i_resp !== 1'b0 || o_d_resp !== 1'b0) begin
            failures++;
            $display("FAIL idle_resp: iresp=%b dresp=%b want 0", o_i_resp, o_d_resp);
        end
        @(negedge clk);
        main_resp = 1'b0;
        checks++;
        if (o_main_read !== 1'b0 || o_main_write !== 1'b0) begin
            failures++;
            $display("FAIL idle_resp_strobe: rd=%b wr=%b want 0", o_main_read, o_main_write);
        end
    endtask

    task automatic test_tie_priority();
        logic [255:0] w;
        w = rand_line();
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
        set_req(1'b1, 1'b0, 1'b1, 32'h0000_0200, w);
        run_txn("tie_d_first", 1'b1, 1'b1, 32'h0000_0200, w, 2);
        drop_req(1'b1);
        run_txn("tie_i_second", 1'b0, 1'b0, 32'h0000_0100, '0, 0);
        drop_req(1'b0);
    endtask

    task automatic test_starvation();
        logic [31:0]  a;
        logic [255:0] w;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0400, '0);
        for (int k = 0; k < LIMIT; k++) begin
            a = 32'h0000_1000 + 32'(k) * 32'h20;
            w = rand_line();
            set_req(1'b1, 1'b0, 1'b1, a, w);
            run_txn("starve_d", 1'b1, 1'b1, a, w, k % 2);
        end
        checks++;
        if (dut_p.starve_cnt_q !== 3'(LIMIT)) begin
            failures++;
            $display("FAIL starve_cnt_full: starve_cnt=%0d want %0d", dut_p.starve_cnt_q, LIMIT);
        end
        a = 32'h0000_2000;
        set_req(1'b1, 1'b1, 1'b0, a, '0);
        run_txn("starve_i", 1'b0, 1'b0, 32'h0000_0400, '0, 1);
        drop_req(1'b0);
        checks++;
        if (dut_p.starve_cnt_q !== '0) begin
            failures++;
            $display("FAIL starve_cnt_clear: starve_cnt=%0d want 0", dut_p.starve_cnt_q);
        end
        run_txn("starve_d_after", 1'b1, 1'b0, a, '0, 0);
        drop_req(1'b1);
    endtask

    task automatic test_addr_hold();
        bit ok;
        int cyc;
        logic [255:0] w1;
        w1 = rand_line();
        set_req(1'b1, 1'b0, 1'b1, 32'h0000_0200, w1);
        wait_strobe("hold", ok, cyc);
        if (ok) begin
            check_grant("hold", 1'b1, 32'h0000_0200, w1);
            set_req(1'b1, 1'b1, 1'b0, 32'h0000_0300, rand_line());
            @(negedge clk);
            checks++;
            if (o_main_address !== 32'h0000_0200 || o_main_wdata !== w1 || o_main_write !== 1'b1) begin
                failures++;
                $display("FAIL hold_payload: addr=%h wr=%b, want addr=00000200 wr=1 and original wdata",
                         o_main_address, o_main_write);
            end
            finish_txn("hold", 1'b1, 1'b1, 32'h0000_0200, 2, rand_line());
        end
        run_txn("hold_next", 1'b1, 1'b0, 32'h0000_0300, '0, 0);
        drop_req(1'b1);
        // Read+write together is a write; request dropped right after grant.
        w1 = rand_line();
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_0500, w1);
        wait_strobe("drop", ok, cyc);
        if (ok) begin
            check_grant("drop_rw", 1'b1, 32'h0000_0500, w1);
            drop_req(1'b0);
            finish_txn("drop", 1'b0, 1'b1, 32'h0000_0500, 2, rand_line());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0600, '0);
        wait_strobe("rst_mid", ok, cyc);
        #2;
        reset_n = 1'b0;
        main_resp = 1'b1;
        #1;
        checks++;
        if (o_main_read !== 1'b0 || o_i_resp !== 1'b0 || o_d_resp !== 1'b0 || o_main_address !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: rd=%b iresp=%b dresp=%b addr=%h want 0",
                     o_main_read, o_i_resp, o_d_resp, o_main_address);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_main_read !== 1'b0 || o_i_resp !== 1'b0 || o_d_resp !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_held: rd=%b iresp=%b dresp=%b want 0", o_main_read, o_i_resp, o_d_resp);
        end
        main_resp = 1'b0;
        drop_req(1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_main_read !== 1'b0 || o_main_write !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_grant: rd=%b wr=%b want 0", o_main_read, o_main_write);
        end
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0640, '0);
        run_txn("rst_mid_after", 1'b0, 1'b0, 32'h0000_0640, '0, 1);
        drop_req(1'b0);
    endtask

    task automatic test_round_robin();
        logic [255:0] w;
        sel = 1'b1;
        do_reset();
        w = rand_line();
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
        set_req(1'b1, 1'b0, 1'b1, 32'h0000_2000, w);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) run_txn("rr_d", 1'b1, 1'b1, 32'h0000_2000, w, 1);
            else            run_txn("rr_i", 1'b0, 1'b0, 32'h0000_1000, '0, 1);
        end
        drop_req(1'b0); drop_req(1'b1);
        sel = 1'b0;
    endtask

    typedef struct {
        bit           v;
        bit           rd;
        bit           wr;
        logic [31:0]  a;
        logic [255:0] w;
    } req_t;

    // Random traffic against a request-level model: which side wins is
    // decided from the pending set, a starvation count and the last winner.
    task automatic test_random(input bit rr, input int n);
        req_t pend[2];
        int   starve = 0;
        int   last = 0;
        int   win;
        int   kind;
        sel = rr;
        do_reset();
        for (int s = 0; s < 2; s++) pend[s].v = 1'b0;
        for (int t = 0; t < n + 2; t++) begin
            if (t < n) begin
                for (int s = 0; s < 2; s++) begin
                    if (!pend[s].v && $urandom_range(0, 99) < 60) begin
                        kind = int'($urandom_range(0, 2));
                        pend[s].v  = 1'b1;
                        pend[s].rd = (kind != 1);
                        pend[s].wr = (kind != 0);
                        pend[s].a  = {$urandom() & 32'hFFFF_FFE0};
                        pend[s].w  = rand_line();
                        set_req(s[0], pend[s].rd, pend[s].wr, pend[s].a, pend[s].w);
                    end
                end
                if (!pend[0].v && !pend[1].v) begin
                    win = int'($urandom_range(0, 1));
                    pend[win].v  = 1'b1;
                    pend[win].rd = 1'b1;
                    pend[win].wr = 1'b0;
                    pend[win].a  = {$urandom() & 32'hFFFF_FFE0};
                    pend[win].w  = rand_line();
                    set_req(win[0], 1'b1, 1'b0, pend[win].a, pend[win].w);
                end
            end
            if (!pend[0].v && !pend[1].v) break;
            if (pend[0].v && pend[1].v) begin
                if (rr) win = (last == 0) ? 1 : 0;
                else    win = (starve == LIMIT) ? 0 : 1;
            end else begin
                win = pend[1].v ? 1 : 0;
            end
            if (win == 1) begin
                if (pend[0].v && starve < LIMIT) starve++;
            end else begin
                starve = 0;
            end
            last = win;
            run_txn(rr ? "rand_rr" : "rand_pri", win[0], pend[win].wr, pend[win].a, pend[win].w,
                    int'($urandom_range(0, 3)));
            pend[win].v = 1'b0;
            drop_req(win[0]);
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        reset_n = 1'b1;
        main_resp = 1'b0;
        main_rdata = '0;
        i_read = 1'b1; i_write = 1'b0; i_addr = 32'h0000_0040; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b1; d_addr = 32'h0000_0080; d_wdata = '0;
        #1;
        reset_n = 1'b0;
        main_resp = 1'b1;
        test_reset();
        test_lone_i_read();
        test_tie_priority();
        test_starvation();
        test_addr_hold();
        test_reset_mid();
        test_round_robin();
        test_random(1'b0, 30);
        test_random(1'b1, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
